imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 183 ++++++++++++++++++
 tb/tb_imem_loader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream into little-endian 32-bit instruction words and holds the core in reset while loading.
// Optional feature: define IMEM_LOADER_CKSUM_EN to require a trailing mod-256 checksum byte.
module imem_loader #(
    parameter int DEPTH_BYTES = 256,
    parameter int ADDR_W      = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   byte_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_HOLD,
        S_DONE,
        S_ERROR
`ifdef IMEM_LOADER_CKSUM_EN
        , S_CKSUM
`endif
    } state_t;

`ifdef IMEM_LOADER_CKSUM_EN
    localparam state_t DATA_END = S_CKSUM;
`else
    localparam state_t DATA_END = S_HOLD;
`endif

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH_BYTES);
    localparam logic [3:0]      HOLD_LAST  = 4'(HOLD_CYCLES);

    state_t            state, state_nxt;
    logic [31:0]       word_buf;
    logic [3:0]        hold_cnt;
    logic [1:0]        pos;
    logic [ADDR_W-1:0] word_addr;
    logic              accept, do_start, take_byte, write_word, flush, fail, release_core;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]        sum;
`endif

    assign pos       = byte_count[1:0];
    assign word_addr = {byte_count[ADDR_W-1:2], 2'b00};
    assign accept    = s_valid && s_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        s_ready      = 1'b0;
        busy         = 1'b1;
        do_start     = 1'b0;
        take_byte    = 1'b0;
        write_word   = 1'b0;
        flush        = 1'b0;
        fail         = 1'b0;
        release_core = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                busy = 1'b0;
                if (start) begin
                    do_start  = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                s_ready = 1'b1;
                if (accept) begin
                    if (byte_count == FULL_COUNT) begin
                        fail      = 1'b1;
                        state_nxt = S_ERROR;
                    end else begin
                        take_byte  = 1'b1;
                        write_word = (pos == 2'd3);
                        if (s_last) state_nxt = (pos == 2'd3) ? DATA_END : S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                flush     = 1'b1;
                state_nxt = DATA_END;
            end
            S_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    release_core = 1'b1;
                    state_nxt    = S_DONE;
                end
            end
`ifdef IMEM_LOADER_CKSUM_EN
            S_CKSUM: begin
                s_ready = 1'b1;
                if (accept) begin
                    if (s_data == sum) begin
                        state_nxt = S_HOLD;
                    end else begin
                        fail      = 1'b1;
                        state_nxt = S_ERROR;
                    end
                end
            end
`endif
            default: begin
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; later assignments in this block win.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the partial word buffer is reset too, so a load cut short by reset never leaks into memory.
            word_buf   <= '0;
            byte_count <= '0;
            hold_cnt   <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
            sum        <= '0;
`endif
        end else begin
            mem_we   <= write_word || flush;
            hold_cnt <= (state == S_HOLD) ? hold_cnt + 1'b1 : 4'd0;
            if (do_start) begin
                word_buf   <= '0;
                byte_count <= '0;
                cpu_reset  <= 1'b1;
                done       <= 1'b0;
                err        <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
                sum        <= '0;
`endif
            end
            if (take_byte) begin
                byte_count <= byte_count + 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
                sum        <= sum + s_data;
`endif
                if (write_word) begin
                    mem_addr  <= word_addr;
                    mem_wdata <= {s_data, word_buf[23:0]};
                    word_buf  <= '0;
                end else begin
                    word_buf[{pos, 3'b000} +: 8] <= s_data;
                end
            end
            // Unused upper bytes are already zero because the buffer is cleared after every write.
            if (flush) begin
                mem_addr  <= word_addr;
                mem_wdata <= word_buf;
                word_buf  <= '0;
            end
            if (fail) err <= 1'b1;
            if (release_core) begin
                cpu_reset <= 1'b0;
                done      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized byte streams compared against a word-packing reference model.
// Compile with IMEM_LOADER_CKSUM_EN defined to exercise the checksum path.
module tb_imem_loader;

    localparam int DEPTH_BYTES = 256;
    localparam int ADDR_W      = 8;
    localparam int HOLD_CYCLES = 2;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic              s_valid;
    logic              s_ready;
    logic [7:0]        s_data;
    logic              s_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   byte_count;

    imem_loader #(
        .DEPTH_BYTES(DEPTH_BYTES),
        .ADDR_W     (ADDR_W),
        .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .byte_count(byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    wr_t  obs_q[$];
    int   cyc = 0;
    int   last_we_cyc = -1;
    int   fall_cyc = -1;
    logic prev_cpu_reset = 1'b1;

    // Write and cpu_reset monitor, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (reset_n && mem_we) begin
            obs_q.push_back('{mem_addr, mem_wdata});
            last_we_cyc = cyc;
        end
        if (prev_cpu_reset && !cpu_reset) fall_cyc = cyc;
        prev_cpu_reset = cpu_reset;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_s_ready"},    64'(s_ready),    64'd0);
        check({pfx, "_mem_we"},     64'(mem_we),     64'd0);
        check({pfx, "_mem_addr"},   64'(mem_addr),   64'd0);
        check({pfx, "_mem_wdata"},  64'(mem_wdata),  64'd0);
        check({pfx, "_cpu_reset"},  64'(cpu_reset),  64'd1);
        check({pfx, "_busy"},       64'(busy),       64'd0);
        check({pfx, "_done"},       64'(done),       64'd0);
        check({pfx, "_err"},        64'(err),        64'd0);
        check({pfx, "_byte_count"}, 64'(byte_count), 64'd0);
    endtask

    // Start pulse, optionally colliding with a stray valid byte that must be ignored.
    task automatic pulse_start;
        start   = 1'b1;
        s_valid = 1'($urandom_range(1));
        s_data  = 8'($urandom);
        s_last  = 1'($urandom_range(1));
        tick();
        start   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_bytes(input byte_q_t data, input int gap_pct, input bit with_last);
        int idx   = 0;
        int guard = 0;
        bit acc;
        while (idx < data.size() && guard < 4000) begin
            s_valid = ($urandom_range(99) >= gap_pct);
            s_data  = s_valid ? data[idx] : 8'($urandom);
            s_last  = s_valid ? (with_last && idx == data.size() - 1) : 1'($urandom_range(1));
            start   = ($urandom_range(7) == 0);
            @(negedge clk);
            acc = s_valid && s_ready;
            tick();
            if (acc) idx++;
            guard++;
        end
        start   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("stream_progress", 64'(idx), 64'(data.size()));
    endtask

    task automatic wait_idle;
        int k = 0;
        @(negedge clk);
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", 64'(busy), 64'd0);
        tick();
    endtask

    task automatic run_load(input byte_q_t data, input int gap_pct, input bit bad_cksum, input string tag);
        int   n_data;
        bit   ovf;
        bit   err_exp;
        int   held;
        wr_t  exp_q[$];
`ifdef IMEM_LOADER_CKSUM_EN
        logic [7:0] sum = 8'd0;
        byte_q_t    ck;
`endif
        ovf     = data.size() > DEPTH_BYTES;
        n_data  = ovf ? DEPTH_BYTES : data.size();
        err_exp = ovf || bad_cksum;
        for (int w = 0; 4 * w < n_data; w++) begin
            logic [31:0] word = 32'd0;
            for (int j = 0; j < 4; j++)
                if (4 * w + j < n_data) word = word | (32'(data[4 * w + j]) << (8 * j));
            exp_q.push_back('{ADDR_W'(4 * w), word});
        end
`ifdef IMEM_LOADER_CKSUM_EN
        for (int i = 0; i < n_data; i++) sum = sum + data[i];
`endif
        obs_q.delete();
        fall_cyc    = -1;
        last_we_cyc = -1;

        pulse_start();
        check({tag, "_start_busy"},    64'(busy),       64'd1);
        check({tag, "_start_ready"},   64'(s_ready),    64'd1);
        check({tag, "_start_count"},   64'(byte_count), 64'd0);
        check({tag, "_start_flags"},   64'({cpu_reset, done, err}), 64'b100);

        send_bytes(data, gap_pct, 1'b1);
`ifdef IMEM_LOADER_CKSUM_EN
        if (!ovf) begin
            ck.push_back(bad_cksum ? sum + 8'd1 : sum);
            send_bytes(ck, gap_pct, 1'b1);
        end
`else
        @(negedge clk);
        check({tag, "_ready_after_last"}, 64'(s_ready), 64'd0);
        tick();
`endif
        wait_idle();

        check({tag, "_n_writes"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check({tag, "_addr"}, 64'(obs_q[i].addr), 64'(exp_q[i].addr));
            check({tag, "_data"}, 64'(obs_q[i].data), 64'(exp_q[i].data));
        end
        check({tag, "_done"},      64'(done),      64'(!err_exp));
        check({tag, "_err"},       64'(err),       64'(err_exp));
        check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(err_exp));
        if (!ovf) check({tag, "_byte_count"}, 64'(byte_count), 64'(n_data));
        if (!err_exp) begin
            held = fall_cyc - last_we_cyc - 1;
`ifdef IMEM_LOADER_CKSUM_EN
            check({tag, "_hold_min"}, 64'(held >= HOLD_CYCLES), 64'd1);
`else
            check({tag, "_hold"}, 64'(held), 64'(HOLD_CYCLES));
`endif
        end
    endtask

    initial begin
        byte_q_t prog036;
        byte_q_t prog037;
        byte_q_t q;
        reset_n = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'd0;
        s_last  = 1'b0;
        prog036 = '{8'hb3, 8'h81, 8'h20, 8'h00, 8'h33, 8'h82, 8'h11, 8'h40};
        prog037 = '{8'h23, 8'h20, 8'h40};

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        reset_n = 1'b1;
        tick();

        // Valid bytes while idle must not be taken.
        s_valid = 1'b1;
        s_data  = 8'h55;
        repeat (3) tick();
        check("idle_valid_count", 64'(byte_count), 64'd0);
        check("idle_valid_ready", 64'(s_ready),    64'd0);
        s_valid = 1'b0;

        run_load(prog036, 0, 1'b0, "r036");
        if (obs_q.size() == 2) begin
            check("r036_w0", 64'({obs_q[0].addr, obs_q[0].data}), 64'({8'h00, 32'h002081b3}));
            check("r036_w1", 64'({obs_q[1].addr, obs_q[1].data}), 64'({8'h04, 32'h40118233}));
        end

        run_load(prog037, 0, 1'b0, "r037");
        if (obs_q.size() == 1) check("r037_w0", 64'(obs_q[0].data), 64'h00402023);

        run_load(prog036, 40, 1'b0, "r041");
        if (obs_q.size() == 2) begin
            check("r041_w0", 64'(obs_q[0].data), 64'h002081b3);
            check("r041_w1", 64'(obs_q[1].data), 64'h40118233);
        end

        for (int it = 0; it < 6; it++) begin
            int len = $urandom_range(1, 40);
            q.delete();
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            run_load(q, 30, 1'b0, "rand");
        end

        q.delete();
        for (int i = 0; i < DEPTH_BYTES + 1; i++) q.push_back(8'($urandom));
        run_load(q, 0, 1'b0, "r038");
        check("r038_writes", 64'(obs_q.size()), 64'(DEPTH_BYTES / 4));

        // Reset mid-load after six bytes: only word 0 may ever reach memory.
        obs_q.delete();
        pulse_start();
        q = prog036[0:5];
        send_bytes(q, 0, 1'b0);
        repeat (2) tick();
        reset_n = 1'b0;
        #1;
        check_reset_vals("r039");
        check("r039_writes", 64'(obs_q.size()), 64'd1);
        if (obs_q.size() >= 1)
            check("r039_w0", 64'({obs_q[0].addr, obs_q[0].data}), 64'({8'h00, 32'h002081b3}));
        tick();
        reset_n = 1'b1;
        tick();
        run_load(prog036, 0, 1'b0, "r039_reload");
        if (obs_q.size() >= 1) check("r039_reload_addr0", 64'(obs_q[0].addr), 64'd0);

`ifdef IMEM_LOADER_CKSUM_EN
        q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load(q, 0, 1'b0, "r040_ok");
        run_load(q, 0, 1'b1, "r040_bad");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
